// File: rtl/scan_chain_ctrl.sv
// Scan-shift controller: serially loads a pattern into a scan chain, pulses one capture
// cycle, then unloads the captured state (overlapped with the next load) as a parallel response.
module scan_chain_ctrl #(
  parameter int unsigned CHAIN_LEN = 8,
  parameter int unsigned CNT_W     = $clog2(CHAIN_LEN)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [CHAIN_LEN-1:0] pat_i,
  input  logic                 pat_valid_i,
  output logic                 pat_ready_o,
  input  logic                 so_i,
  output logic                 se_o,
  output logic                 si_o,
  output logic                 cen_o,
  output logic [CHAIN_LEN-1:0] rsp_o,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic                 busy_o
);

  typedef enum logic [1:0] {StIdle, StShift, StCapt, StStall} state_e;

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(CHAIN_LEN - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 load_q, load_d;
  logic                 unload_q, unload_d;
  logic [CHAIN_LEN-1:0] pat_q, pat_d;
  logic [CHAIN_LEN-1:0] rsp_q, rsp_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 se_q, se_d;
  logic                 si_q, si_d;
  logic                 cen_q, cen_d;
  logic                 resp_free;

  assign resp_free = !rsp_valid_q || rsp_ready_i;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    load_d      = load_q;
    unload_d    = unload_q;
    pat_d       = pat_q;
    rsp_d       = rsp_q;
    rsp_valid_d = rsp_valid_q && !rsp_ready_i;
    pat_ready_o = 1'b0;

    case (state_q)
      StIdle: begin
        pat_ready_o = 1'b1;
        if (pat_valid_i) begin
          pat_d    = pat_i;
          state_d  = StShift;
          load_d   = 1'b1;
          unload_d = 1'b0;
          cnt_d    = '0;
        end
      end
      StShift: begin
        cnt_d = cnt_q + 1'b1;
        // SO presents cell CHAIN_LEN-1-cnt of the captured state on this edge
        if (unload_q) begin
          rsp_d[LastCnt - cnt_q] = so_i;
        end
        if (cnt_q == LastCnt) begin
          cnt_d = '0;
          if (unload_q) begin
            rsp_valid_d = 1'b1;
          end
          if (load_q) begin
            state_d = StCapt;
          end else begin
            state_d  = StIdle;
            load_d   = 1'b0;
            unload_d = 1'b0;
          end
        end
      end
      StCapt, StStall: begin
        pat_ready_o = resp_free;
        if (resp_free) begin
          state_d  = StShift;
          cnt_d    = '0;
          unload_d = 1'b1;
          load_d   = pat_valid_i;
          if (pat_valid_i) begin
            pat_d = pat_i;
          end
        end else begin
          // Chain clock stays gated so the captured state survives the wait
          state_d = StStall;
        end
      end
      default: state_d = StIdle;
    endcase

    se_d  = (state_d == StShift);
    cen_d = (state_d == StShift) || (state_d == StCapt);
    si_d  = (state_d == StShift) && load_d ? pat_d[LastCnt - cnt_d] : 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      load_q      <= 1'b0;
      unload_q    <= 1'b0;
      pat_q       <= '0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
      se_q        <= 1'b0;
      si_q        <= 1'b0;
      cen_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      load_q      <= load_d;
      unload_q    <= unload_d;
      pat_q       <= pat_d;
      rsp_q       <= rsp_d;
      rsp_valid_q <= rsp_valid_d;
      se_q        <= se_d;
      si_q        <= si_d;
      cen_q       <= cen_d;
    end
  end

  assign se_o        = se_q;
  assign si_o        = si_q;
  assign cen_o       = cen_q;
  assign rsp_o       = rsp_q;
  assign rsp_valid_o = rsp_valid_q;
  assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: behavioural scan chains (capture D = ~Q) and a response scoreboard.
module tb_scan_chain_ctrl;

  localparam int unsigned N = 4;
  localparam int unsigned M = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0] pat_a, rsp_a;
  logic         pat_valid_a, pat_ready_a, so_a, se_a, si_a, cen_a;
  logic         rsp_valid_a, rsp_ready_a, busy_a;
  logic [M-1:0] pat_b, rsp_b;
  logic         pat_valid_b, pat_ready_b, so_b, se_b, si_b, cen_b;
  logic         rsp_valid_b, rsp_ready_b, busy_b;

  scan_chain_ctrl #(.CHAIN_LEN(N)) u_dut_a (
    .clk_i       (clk),
    .rst_i       (rst),
    .pat_i       (pat_a),
    .pat_valid_i (pat_valid_a),
    .pat_ready_o (pat_ready_a),
    .so_i        (so_a),
    .se_o        (se_a),
    .si_o        (si_a),
    .cen_o       (cen_a),
    .rsp_o       (rsp_a),
    .rsp_valid_o (rsp_valid_a),
    .rsp_ready_i (rsp_ready_a),
    .busy_o      (busy_a)
  );

  scan_chain_ctrl #(.CHAIN_LEN(M)) u_dut_b (
    .clk_i       (clk),
    .rst_i       (rst),
    .pat_i       (pat_b),
    .pat_valid_i (pat_valid_b),
    .pat_ready_o (pat_ready_b),
    .so_i        (so_b),
    .se_o        (se_b),
    .si_o        (si_b),
    .cen_o       (cen_b),
    .rsp_o       (rsp_b),
    .rsp_valid_o (rsp_valid_b),
    .rsp_ready_i (rsp_ready_b),
    .busy_o      (busy_b)
  );

  // Scan chains: shift when SE=1, functional capture of ~Q when SE=0, frozen when CEN=0
  logic [N-1:0] chain_a = '0;
  logic [M-1:0] chain_b = '0;
  assign so_a = chain_a[N-1];
  assign so_b = chain_b[M-1];
  always @(posedge clk) if (cen_a) chain_a <= se_a ? {chain_a[N-2:0], si_a} : ~chain_a;
  always @(posedge clk) if (cen_b) chain_b <= se_b ? {chain_b[M-2:0], si_b} : ~chain_b;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [N-1:0] exp_q[$];
  int rsp_seen = 0;

  always @(posedge clk) begin
    if (!rst) begin
      if (pat_valid_a && pat_ready_a) exp_q.push_back(~pat_a);
      if (rsp_valid_a && rsp_ready_a) begin
        rsp_seen++;
        if (exp_q.size() == 0) check_eq("sb_depth", exp_q.size(), 1);
        else check_eq("rsp", rsp_a, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_pins(input string tag, input logic se, input logic si, input logic cen);
    check_eq({tag, ".se"}, se_a, se);
    check_eq({tag, ".si"}, si_a, si);
    check_eq({tag, ".cen"}, cen_a, cen);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy_a || rsp_valid_a) && n < 64) begin
      tick();
      n++;
    end
    check_eq({tag, ".pending"}, exp_q.size(), 0);
    check_eq({tag, ".busy"}, busy_a, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] pv;
    logic [M-1:0] pv_b;
    int n;

    rst = 1'b1;
    pat_a = '0; pat_valid_a = 1'b0; rsp_ready_a = 1'b1;
    pat_b = '0; pat_valid_b = 1'b0; rsp_ready_b = 1'b1;
    #1;
    chk_pins("reset", 1'b0, 1'b0, 1'b0);
    check_eq("reset.rsp", rsp_a, '0);
    check_eq("reset.rsp_valid", rsp_valid_a, 1'b0);
    check_eq("reset.busy", busy_a, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Single pattern
    pv = 4'b1011;
    pat_a = pv; pat_valid_a = 1'b1;
    check_eq("t1.idle_ready", pat_ready_a, 1'b1);
    tick();
    pat_valid_a = 1'b0;
    for (int i = 0; i < N; i++) begin
      chk_pins("t1.load", 1'b1, pv[N-1-i], 1'b1);
      check_eq("t1.no_early_rsp", rsp_valid_a, 1'b0);
      tick();
    end
    chk_pins("t1.capt", 1'b0, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < N; i++) begin
      chk_pins("t1.unload", 1'b1, 1'b0, 1'b1);
      tick();
    end
    check_eq("t1.rsp", rsp_a, 4'b0100);
    check_eq("t1.rsp_valid", rsp_valid_a, 1'b1);
    check_eq("t1.busy", busy_a, 1'b0);
    check_eq("t1.cen_idle", cen_a, 1'b0);
    tick();
    check_eq("t1.rsp_pulse", rsp_valid_a, 1'b0);

    // Back-to-back, second pattern held valid through the first shift
    pat_a = 4'b1011; pat_valid_a = 1'b1;
    tick();
    pat_a = 4'b0000;
    for (int i = 0; i < N; i++) begin
      check_eq("t2.shift_not_ready", pat_ready_a, 1'b0);
      check_eq("t2.shift_se", se_a, 1'b1);
      tick();
    end
    check_eq("t2.capt_ready", pat_ready_a, 1'b1);
    tick();
    pat_valid_a = 1'b0;
    for (int i = 0; i < N; i++) begin
      chk_pins("t2.overlap", 1'b1, 1'b0, 1'b1);
      tick();
    end
    check_eq("t2.capt2_rsp", rsp_a, 4'b0100);
    check_eq("t2.capt2_rsp_valid", rsp_valid_a, 1'b1);
    chk_pins("t2.capt2", 1'b0, 1'b0, 1'b1);
    wait_drain("t2.drain");

    // Stall on a full response register
    pat_a = 4'b1011; pat_valid_a = 1'b1;
    tick();
    pat_a = 4'b0000;
    repeat (N) tick();
    tick();
    pat_a = 4'b0110;
    rsp_ready_a = 1'b0;
    repeat (N) tick();
    check_eq("t3.capt2_ready", pat_ready_a, 1'b0);
    check_eq("t3.capt2_cen", cen_a, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      check_eq("t3.stall_cen", cen_a, 1'b0);
      check_eq("t3.stall_ready", pat_ready_a, 1'b0);
      check_eq("t3.stall_busy", busy_a, 1'b1);
      check_eq("t3.stall_rsp", rsp_a, 4'b0100);
      check_eq("t3.stall_rsp_valid", rsp_valid_a, 1'b1);
      tick();
    end
    rsp_ready_a = 1'b1;
    tick();
    pat_valid_a = 1'b0;
    check_eq("t3.resume_se", se_a, 1'b1);
    wait_drain("t3.drain");

    // Reset in the middle of a shift, with a response still held
    rsp_ready_a = 1'b0;
    pat_a = 4'b0011; pat_valid_a = 1'b1;
    tick();
    pat_valid_a = 1'b0;
    n = 0;
    while (!rsp_valid_a && n < 20) begin
      tick();
      n++;
    end
    check_eq("t4.held_rsp", rsp_a, 4'b1100);
    pat_a = 4'b1010; pat_valid_a = 1'b1;
    tick();
    pat_valid_a = 1'b0;
    repeat (2) tick();
    check_eq("t4.pre_se", se_a, 1'b1);
    check_eq("t4.pre_rsp_valid", rsp_valid_a, 1'b1);
    rst = 1'b1;
    #1;
    chk_pins("t4.async", 1'b0, 1'b0, 1'b0);
    check_eq("t4.async_rsp_valid", rsp_valid_a, 1'b0);
    check_eq("t4.async_rsp", rsp_a, '0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    tick();
    check_eq("t4.post_ready", pat_ready_a, 1'b1);
    check_eq("t4.post_busy", busy_a, 1'b0);
    check_eq("t4.post_rsp_valid", rsp_valid_a, 1'b0);
    rsp_ready_a = 1'b1;
    pat_a = 4'b0110; pat_valid_a = 1'b1;
    tick();
    pat_valid_a = 1'b0;
    wait_drain("t4.drain");
    check_eq("rsp_count", rsp_seen, 7);

    // CHAIN_LEN=2: wrap and busy length
    pv_b = 2'b10;
    pat_b = pv_b; pat_valid_b = 1'b1;
    tick();
    pat_valid_b = 1'b0;
    n = 0;
    while (busy_b && n < 20) begin
      if (n < 2) check_eq("t6.si", si_b, pv_b[M-1-n]);
      n++;
      tick();
    end
    check_eq("t6.busy_cycles", n, 5);
    check_eq("t6.rsp", rsp_b, 2'b01);
    check_eq("t6.rsp_valid", rsp_valid_b, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
